serial_byte_rx: RTL
===================

# serial_byte_rx

- Serial-to-parallel receive stage sitting directly upstream of the 8-bit enable-loaded holding register.
- Samples a framed serial line on qualified sample strobes: one start bit (0), WIDTH data bits LSB-first, one stop bit (1).
- Presents the assembled word on `data` with a one-cycle `enable` pulse, which wires straight to the holding register's `data`/`enable` inputs.
- Flags bad stop bits on `frame_err`.

## Interface
- WIDTH, 8, data bits per frame; legal range 2..16; bit counter is $clog2(WIDTH) bits.
- clk  input  1  single clock; all state updates on posedge.
- rst_  input  1  asynchronous, active-low reset.
- sin  input  1  serial line; idle level 1; synchronous to clk.
- bit_en  input  1  sample strobe; `sin` is examined only on posedges where bit_en=1.
- data  output  WIDTH  last good received word, registered.
- enable  output  1  one-cycle load pulse for the downstream register, registered.
- frame_err  output  1  last completed frame had stop bit 0, registered.
- busy  output  1  high when state != IDLE; decoded from the state register only.

## Operation
- **Reset values:** state=IDLE, bit count=0, shift register=0, data=0, enable=0, frame_err=0, busy=0.
- **IDLE:** on bit_en with sin=0, go to DATA and clear count. Otherwise stay in IDLE (sin=1 or bit_en=0).
- **DATA:** on each bit_en:
  - Shift register shifts right with sin entering the MSB, so the first received bit ends up in data[0].
  - Count increments.
  - On the sample where count==WIDTH-1, go to STOP.
  - bit_en=0 holds everything.
- **STOP:** on bit_en:
  - sin=1: data <= shift register, enable <= 1, frame_err <= 0, go to IDLE.
  - sin=0: data unchanged, enable stays 0, frame_err <= 1, go to IDLE.
- **enable:** defaults to 0 on every cycle not covered above, so it is never high for two consecutive cycles.
- **frame_err:** sticky until the next completed frame's stop sample; it is not cleared by a start bit.
- **Line held low:** the failing stop sample returns the block to IDLE. The next bit_en with sin=0 is treated as a new start bit; no extra recovery logic.
- **No start-bit validation or oversampling.** The upstream strobe generator places bit_en mid-bit.

## Timing
- **Latency:**
  - Start bit is sampled at edge S0.
  - Data bits are sampled at the next WIDTH bit_en edges.
  - The stop bit is sampled at the (WIDTH+1)th bit_en edge after S0.
  - data/enable/frame_err update at that same edge and are visible in the following cycle.
  - The downstream register captures data on the posedge after enable rises.
- **bit_en spacing:** arbitrary, including back-to-back every cycle.
  - The minimum frame is WIDTH+2 consecutive bit_en cycles.
  - The next frame's start bit may be sampled on the bit_en immediately after the stop sample.
- **busy:** rises the cycle after the start sample and falls the cycle after the stop sample.
- **Reset mid-frame:**
  - All state returns to reset values immediately, without waiting for clk.
  - No enable is produced and the partial word is discarded.
  - data returns to 0.
- **Reset release:** reception starts at the first bit_en with sin=0 after rst_ is high.
- **Undefined inputs:** with bit_en=0, X on sin must not propagate into state.

## Test plan
- **Reset:** assert rst_=0 mid-cycle with no clock edge -> data=00, enable=0, frame_err=0, busy=0 immediately.
- **Good frame 0xA5:** bit_en every cycle, sin = 0,1,0,1,0,0,1,0,1,1 -> busy high for 9 cycles, then data=A5, enable high exactly one cycle, frame_err=0. Downstream register reads A5 one cycle later.
- **Sparse strobes:** bit_en every 4th cycle, frame 0x3C, with sin toggling randomly between strobes -> data=3C, single enable pulse. Between strobes, state and outputs are unchanged.
- **Framing error:**
  - Send 0x55 with stop bit 0 -> frame_err=1, enable never pulses, data keeps its previous value.
  - Then send good 0x0F -> frame_err=0, data=0F.
- **Back-to-back frames:** 0xFF then 0x00 with no idle bit between -> two enable pulses exactly WIDTH+2 bit_en cycles apart, data=FF then 00.
- **Reset mid-frame:** pulse rst_ low after 4 data bits, then send 0x81 -> no enable for the aborted frame, then data=81 with one enable pulse.

Source files
------------

// File: rtl/serial_byte_rx_if.sv
// Receive-side bundle: serial line and strobe in, assembled word and status out.
interface serial_byte_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sin;
    logic             bit_en;
    logic [WIDTH-1:0] data;
    logic             enable;
    logic             frame_err;
    logic             busy;

    // Receiver side
    modport slave (
        input  sin,
        input  bit_en,
        output data,
        output enable,
        output frame_err,
        output busy
    );

    // Line driver / consumer side
    modport master (
        output sin,
        output bit_en,
        input  data,
        input  enable,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB-first, stop bit,
// sampled only on bit_en. A good stop bit loads data and pulses enable for one
// cycle; a bad stop bit sets the sticky frame_err and leaves data untouched.
module serial_byte_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    serial_byte_rx_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic             enable_q;
    logic             frame_err_q;

    // Frame FSM; everything is gated by bit_en so an undefined sin between strobes is ignored
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            count       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            enable_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            if (bus.bit_en) begin
                case (state)
                    IDLE: begin
                        if (!bus.sin) begin
                            state <= DATA;
                            count <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {bus.sin, shift_q[WIDTH-1:1]};
                        count   <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (bus.sin) begin
                            data_q      <= shift_q;
                            enable_q    <= 1'b1;
                            frame_err_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.enable    = enable_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);

endmodule
